// File: rtl/sonar_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sonar_pkg
// Brief   : Shared types for the ping/echo sequencer: FSM state encoding,
//           echo record layout and a width helper.
// Revision: 1.0 - initial release
// ============================================================================
package sonar_pkg;

  // Sequencer states; encoding is fixed so waveforms read the same everywhere
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_BURST  = 3'd1,
    ST_LISTEN = 3'd2,
    ST_DONE   = 3'd3,
    ST_WAIT   = 3'd4
  } state_t;

  // Echo record fields are sized for the largest supported configuration;
  // users pack only the bits their parameters need into the FIFO.
  localparam int c_rec_ch_w  = 8;
  localparam int c_rec_idx_w = 8;
  localparam int c_rec_tof_w = 32;

  typedef struct packed {
    logic [c_rec_ch_w-1:0]  ch;
    logic [c_rec_idx_w-1:0] idx;
    logic [c_rec_tof_w-1:0] tof;
  } echo_rec_t;

  // Index width for a count of n items, never narrower than one bit
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/echo_fifo.sv
`default_nettype none
// ============================================================================
// Module  : echo_fifo
// Brief   : Synchronous FIFO for captured echo records. DEPTH must be a power
//           of two; pointers carry one wrap bit to tell full from empty.
// Revision: 1.0 - initial release
// ============================================================================
module echo_fifo
  import sonar_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int c_aw = width_of(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw:0]    r_wr_ptr;
  logic [c_aw:0]    r_rd_ptr;
  logic             w_wr;
  logic             w_rd;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                   (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
  assign w_wr    = i_wr_en && !o_full;
  assign w_rd    = i_rd_en && !o_empty;

  // Pointer advance; reset empties the FIFO without touching storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage write; contents only matter between write and read pointers
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr[c_aw-1:0]] <= i_wr_data;
  end

  assign o_rd_data = r_mem[r_rd_ptr[c_aw-1:0]];

endmodule
`default_nettype wire

// File: rtl/ping_echo_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : ping_echo_sequencer
// Brief   : Sonar ping sequencer. Gates the transmitter for a burst, listens
//           on NUM_CH channels for threshold crossings with hysteresis,
//           timestamps echoes and queues them through a FIFO.
// Revision: 1.0 - initial release
// ============================================================================
module ping_echo_sequencer
  import sonar_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int SAMPLE_W       = 16,
  parameter int COUNT_W        = 24,
  parameter int BURST_CYCLES   = 8,
  parameter int BLANK_CYCLES   = 20,
  parameter int TIMEOUT_CYCLES = 100,
  parameter int PERIOD_CYCLES  = 128,
  parameter int MAX_ECHOES     = 2,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                            clk_in,
  input  logic                            rst_n,
  input  logic                            start_in,
  input  logic                            continuous_in,
  input  logic [SAMPLE_W-1:0]             threshold_in,
  input  logic [SAMPLE_W-1:0]             hysteresis_in,
  input  logic [NUM_CH*SAMPLE_W-1:0]      sample_in,
  input  logic                            sample_valid_in,
  output logic                            tx_en_out,
  output logic                            ping_start_out,
  output logic                            echo_valid_out,
  input  logic                            echo_ready_in,
  output logic [width_of(NUM_CH)-1:0]     echo_ch_out,
  output logic [width_of(MAX_ECHOES)-1:0] echo_idx_out,
  output logic [COUNT_W-1:0]              echo_tof_out,
  output logic                            ping_done_out,
  output logic                            busy_out,
  output logic                            overflow_out
);

  localparam int c_ch_w    = width_of(NUM_CH);
  localparam int c_idx_w   = width_of(MAX_ECHOES);
  localparam int c_cnt_w   = $clog2(MAX_ECHOES + 1);
  localparam int c_fifo_w  = c_ch_w + c_idx_w + COUNT_W;

  localparam logic [COUNT_W-1:0] c_burst_last  = COUNT_W'(BURST_CYCLES - 1);
  // DONE itself occupies the TIMEOUT_CYCLES-1 count, so LISTEN ends one earlier
  localparam logic [COUNT_W-1:0] c_listen_last = COUNT_W'(TIMEOUT_CYCLES - 2);
  localparam logic [COUNT_W-1:0] c_period_last = COUNT_W'(PERIOD_CYCLES - 1);
  localparam logic [COUNT_W-1:0] c_blank       = COUNT_W'(BLANK_CYCLES);
  localparam logic [c_cnt_w-1:0] c_max_echoes  = c_cnt_w'(MAX_ECHOES);

  state_t                r_state;
  state_t                w_state_next;
  logic                  w_ping_start_next;
  logic [COUNT_W-1:0]    r_tof;
  logic                  r_overflow;
  logic                  w_detect_win;

  logic signed [SAMPLE_W+1:0] w_thr_ext;
  logic signed [SAMPLE_W+1:0] w_hyst_ext;
  logic signed [SAMPLE_W+1:0] w_rearm_lvl;

  logic [NUM_CH-1:0]     w_pend_vld;
  logic [NUM_CH-1:0]     w_drop;
  echo_rec_t             w_pend_rec [NUM_CH];
  logic                  w_push_any;
  logic                  w_push;
  logic [c_ch_w-1:0]     w_push_sel;
  echo_rec_t             w_push_rec;
  logic                  w_unused_rec;

  logic [c_fifo_w-1:0]   w_fifo_wdata;
  logic [c_fifo_w-1:0]   w_fifo_rdata;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;

  // FSM state register
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // FSM next-state: timing is driven entirely by the time-of-flight counter
  always_comb begin
    w_state_next      = r_state;
    w_ping_start_next = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start_in) begin
          w_state_next      = ST_BURST;
          w_ping_start_next = 1'b1;
        end
      end
      ST_BURST:  if (r_tof == c_burst_last)  w_state_next = ST_LISTEN;
      ST_LISTEN: if (r_tof == c_listen_last) w_state_next = ST_DONE;
      ST_DONE:   w_state_next = continuous_in ? ST_WAIT : ST_IDLE;
      ST_WAIT: begin
        if (!continuous_in) begin
          w_state_next = ST_IDLE;
        end else if (r_tof == c_period_last) begin
          w_state_next      = ST_BURST;
          w_ping_start_next = 1'b1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // FSM outputs decoded from the current state
  always_comb begin
    tx_en_out      = 1'b0;
    ping_start_out = 1'b0;
    ping_done_out  = 1'b0;
    busy_out       = (r_state != ST_IDLE);
    case (r_state)
      ST_BURST: begin
        tx_en_out      = 1'b1;
        ping_start_out = (r_tof == '0);
      end
      ST_DONE: ping_done_out = 1'b1;
      default: ;
    endcase
  end

  // Time-of-flight counter: zero at burst start, saturating, parked in IDLE
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_tof <= '0;
    end else if (w_state_next == ST_IDLE || w_ping_start_next) begin
      r_tof <= '0;
    end else if (r_tof != '1) begin
      r_tof <= r_tof + 1'b1;
    end
  end

  assign w_detect_win = (r_state == ST_LISTEN) && (r_tof >= c_blank);

  // Threshold arithmetic widened by two bits so threshold - hysteresis cannot wrap
  assign w_thr_ext   = {{2{threshold_in[SAMPLE_W-1]}}, threshold_in};
  assign w_hyst_ext  = {2'b00, hysteresis_in};
  assign w_rearm_lvl = w_thr_ext - w_hyst_ext;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic signed [SAMPLE_W+1:0] w_s_ext;
    logic                       w_cross;
    logic                       w_room;
    logic                       w_slot_free;
    logic                       w_capture;
    logic                       r_armed;
    logic                       r_pend_vld;
    logic [c_cnt_w-1:0]         r_cnt;
    echo_rec_t                  r_pend;

    assign w_s_ext     = {{2{sample_in[g*SAMPLE_W+SAMPLE_W-1]}}, sample_in[g*SAMPLE_W +: SAMPLE_W]};
    assign w_cross     = sample_valid_in && r_armed && w_detect_win && (w_s_ext > w_thr_ext);
    assign w_room      = (r_cnt < c_max_echoes);
    // A slot being pushed this cycle can take a new capture
    assign w_slot_free = !r_pend_vld || (w_push && (w_push_sel == c_ch_w'(g)));
    assign w_capture   = w_cross && w_room && w_slot_free;
    assign w_drop[g]   = w_cross && w_room && !w_slot_free;

    // Arming and per-ping echo ordinal; any crossing disarms until hysteresis clears
    always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
        r_armed <= 1'b1;
        r_cnt   <= '0;
      end else if (w_ping_start_next) begin
        r_armed <= 1'b1;
        r_cnt   <= '0;
      end else if (w_cross) begin
        r_armed <= 1'b0;
        if (w_capture) r_cnt <= r_cnt + 1'b1;
      end else if (sample_valid_in && (w_s_ext < w_rearm_lvl)) begin
        r_armed <= 1'b1;
      end
    end

    // Single-entry pending slot between detection and the FIFO
    always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
        r_pend_vld <= 1'b0;
        r_pend     <= '0;
      end else if (w_capture) begin
        r_pend_vld <= 1'b1;
        r_pend.ch  <= c_rec_ch_w'(g);
        r_pend.idx <= c_rec_idx_w'(r_cnt);
        r_pend.tof <= c_rec_tof_w'(r_tof);
      end else if (w_push && (w_push_sel == c_ch_w'(g))) begin
        r_pend_vld <= 1'b0;
      end
    end

    assign w_pend_vld[g] = r_pend_vld;
    assign w_pend_rec[g] = r_pend;
  end

  // Fixed-priority push arbiter: lowest-numbered pending channel wins
  always_comb begin
    w_push_any = 1'b0;
    w_push_sel = '0;
    w_push_rec = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (w_pend_vld[i]) begin
        w_push_any = 1'b1;
        w_push_sel = c_ch_w'(i);
        w_push_rec = w_pend_rec[i];
      end
    end
  end

  assign w_push       = w_push_any && !w_fifo_full;
  assign w_fifo_wdata = {w_push_rec.ch[c_ch_w-1:0], w_push_rec.idx[c_idx_w-1:0],
                         w_push_rec.tof[COUNT_W-1:0]};
  // Record fields above the configured widths are always zero
  assign w_unused_rec = ^w_push_rec;

  // Sticky overflow, cleared as the next ping begins
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n)                 r_overflow <= 1'b0;
    else if (w_ping_start_next) r_overflow <= 1'b0;
    else if (|w_drop)           r_overflow <= 1'b1;
  end

  assign overflow_out = r_overflow;

  echo_fifo #(
    .WIDTH (c_fifo_w),
    .DEPTH (FIFO_DEPTH)
  ) u_echo_fifo (
    .clk       (clk_in),
    .rst_n     (rst_n),
    .i_wr_en   (w_push),
    .i_wr_data (w_fifo_wdata),
    .i_rd_en   (echo_valid_out && echo_ready_in),
    .o_rd_data (w_fifo_rdata),
    .o_full    (w_fifo_full),
    .o_empty   (w_fifo_empty)
  );

  // Echo fields are forced low when nothing is offered
  assign echo_valid_out = !w_fifo_empty;
  assign echo_ch_out    = echo_valid_out ? w_fifo_rdata[c_fifo_w-1 -: c_ch_w] : '0;
  assign echo_idx_out   = echo_valid_out ? w_fifo_rdata[COUNT_W +: c_idx_w] : '0;
  assign echo_tof_out   = echo_valid_out ? w_fifo_rdata[COUNT_W-1:0] : '0;

endmodule
`default_nettype wire
